// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decoder feeding a BUF_DEPTH-entry in-order buffer towards EX.
// Optional feature macro RV32M_EN: when defined, OP with funct7=0000001 decodes as multiply/divide.
module decode_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  instr_valid_i,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] instr_pc_i,
  output logic                  instr_ready_o,
  input  logic                  flush_i,
  input  logic                  ex_load_valid_i,
  input  logic [4:0]            ex_load_rd_i,
  input  logic                  ex_ready_i,
  output logic                  ex_valid_o,
  output logic [DATA_WIDTH-1:0] ex_pc_o,
  output logic [4:0]            ex_rs1_o,
  output logic [4:0]            ex_rs2_o,
  output logic [4:0]            ex_rd_o,
  output logic [31:0]           ex_imm_o,
  output logic [3:0]            ex_alu_op_o,
  output logic [3:0]            ex_mem_op_o,
  output logic                  ex_reg_write_o,
  output logic                  ex_mem_rd_en_o,
  output logic                  ex_mem_wr_en_o,
  output logic                  ex_branch_o,
  output logic                  ex_jump_o,
  output logic                  ex_md_en_o,
  output logic [2:0]            ex_md_op_o,
  output logic                  ex_illegal_o,
  output logic [7:0]            illegal_cnt_o
);

  localparam int unsigned PtrW = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [31:0]           imm;
    logic [3:0]            alu_op;
    logic [3:0]            mem_op;
    logic                  reg_write;
    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic                  branch;
    logic                  jump;
`ifdef RV32M_EN
    logic                  md_en;
    logic [2:0]            md_op;
`endif
    logic                  illegal;
  } entry_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_e;

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        sys_ok;
  logic        rs1_used, rs2_used, hazard;
  entry_t      dec;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rd     = instr_i[11:7];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  // ECALL, EBREAK, WFI, MRET
  assign sys_ok = instr_i[31:20] inside {12'h000, 12'h001, 12'h105, 12'h302};

  // Instruction decoder
  always_comb begin
    dec        = '0;
    dec.pc     = instr_pc_i;
    dec.rs1    = rs1;
    dec.rs2    = rs2;
    dec.rd     = rd;
    dec.alu_op = ALU_ADD;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.imm       = imm_u;
        dec.alu_op    = ALU_LUI;
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.imm       = imm_j;
      end
      OPC_JALR: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.imm       = imm_i;
        dec.illegal   = (funct3 != 3'b000);
        rs1_used      = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        dec.imm    = imm_b;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
        case (funct3[2:1])
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: dec.alu_op = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        dec.reg_write = 1'b1;
        dec.mem_rd_en = 1'b1;
        dec.imm       = imm_i;
        dec.mem_op    = {1'b1, funct3};
        rs1_used      = 1'b1;
      end
      OPC_STORE: begin
        dec.mem_wr_en = 1'b1;
        dec.imm       = imm_s;
        dec.mem_op    = {1'b1, funct3};
        dec.illegal   = funct3[2] || (funct3 == 3'b011);
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
        dec.alu_op    = alu_from_f3(funct3, (funct3 == 3'b101) && instr_i[30]);
        rs1_used      = 1'b1;
      end
      OPC_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        if (funct7 == 7'b0000001) begin
`ifdef RV32M_EN
          dec.md_en     = 1'b1;
          dec.md_op     = funct3;
          dec.reg_write = 1'b1;
`else
          dec.illegal   = 1'b1;
`endif
        end else begin
          dec.reg_write = 1'b1;
          dec.alu_op    = alu_from_f3(funct3, instr_i[30]);
        end
      end
      OPC_MISC_MEM: begin
      end
      OPC_SYSTEM: begin
        dec.imm = imm_i;
        if (funct3 == 3'b000) begin
          dec.illegal = !sys_ok || (rs1 != 5'd0) || (rd != 5'd0);
        end else if (funct3 == 3'b100) begin
          dec.illegal = 1'b1;
        end else begin
          dec.reg_write = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal entries still travel to EX but must have no architectural side effects
    if (dec.illegal) begin
      dec.reg_write = 1'b0;
      dec.mem_rd_en = 1'b0;
      dec.mem_wr_en = 1'b0;
    end
    if (rd == 5'd0) dec.reg_write = 1'b0;
  end

  assign hazard = ex_load_valid_i && (ex_load_rd_i != 5'd0) &&
                  ((rs1_used && (ex_load_rd_i == rs1)) || (rs2_used && (ex_load_rd_i == rs2)));

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]      ill_cnt_q, ill_cnt_d;
  entry_t          mem_q [BUF_DEPTH];
  entry_t          head;
  logic            push, pop;

  // Ready depends only on registered occupancy, never on ex_ready_i
  assign instr_ready_o = (state_q != ST_FULL) && !hazard && !flush_i;
  assign push          = instr_valid_i && instr_ready_o;
  assign pop           = ex_valid_o && ex_ready_i;

  // Occupancy FSM next-state
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ill_cnt_d = ill_cnt_q;
    if (push && dec.illegal && (ill_cnt_q != 8'hFF)) ill_cnt_d = ill_cnt_q + 8'd1;
    if (flush_i) begin
      state_d  = ST_EMPTY;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
      if (count_d == '0)                  state_d = ST_EMPTY;
      else if (count_d == CntW'(BUF_DEPTH)) state_d = ST_FULL;
      else                                state_d = ST_PARTIAL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_EMPTY;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ill_cnt_q <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ill_cnt_q <= ill_cnt_d;
      if (push) mem_q[wr_ptr_q] <= dec;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign ex_valid_o     = (state_q != ST_EMPTY);
  assign ex_pc_o        = head.pc;
  assign ex_rs1_o       = head.rs1;
  assign ex_rs2_o       = head.rs2;
  assign ex_rd_o        = head.rd;
  assign ex_imm_o       = head.imm;
  assign ex_alu_op_o    = head.alu_op;
  assign ex_mem_op_o    = head.mem_op;
  assign ex_reg_write_o = head.reg_write;
  assign ex_mem_rd_en_o = head.mem_rd_en;
  assign ex_mem_wr_en_o = head.mem_wr_en;
  assign ex_branch_o    = head.branch;
  assign ex_jump_o      = head.jump;
  assign ex_illegal_o   = head.illegal;
  assign illegal_cnt_o  = ill_cnt_q;
`ifdef RV32M_EN
  assign ex_md_en_o     = head.md_en;
  assign ex_md_op_o     = head.md_op;
`else
  assign ex_md_en_o     = 1'b0;
  assign ex_md_op_o     = 3'b000;
`endif

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the PC width.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the number of decoded-entry buffer slots (power of two, >=2).
REQ-003 SHALL have these ports (clock and reset first):
- clk_i  in  1  sole clock
- rst_ni  in  1  asynchronous active-low reset
- instr_valid_i  in  1  fetch offers an instruction
- instr_i  in  32  instruction word
- instr_pc_i  in  DATA_WIDTH  instruction PC
- instr_ready_o  out  1  stage accepts this cycle
- flush_i  in  1  discard all buffered entries
- ex_load_valid_i  in  1  EX holds a load in flight
- ex_load_rd_i  in  5  destination register of that load
- ex_ready_i  in  1  EX consumes the head entry
- ex_valid_o  out  1  head entry valid
- ex_pc_o  out  DATA_WIDTH  head PC
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  register addresses
- ex_imm_o  out  32  selected immediate (I/S/B/U/J)
- ex_alu_op_o  out  4  ALU operation code
- ex_mem_op_o  out  4  memory operation code
- ex_reg_write_o, ex_mem_rd_en_o, ex_mem_wr_en_o, ex_branch_o, ex_jump_o  out  1 each  control bits
- ex_md_en_o  out  1  multiply/divide operation
- ex_md_op_o  out  3  multiply/divide funct3
- ex_illegal_o  out  1  head entry is an illegal instruction
- illegal_cnt_o  out  8  saturating count of accepted illegal instructions

Function
REQ-004 SHALL decode instr_i combinationally and write the decoded entry into the buffer on the edge where instr_valid_i && instr_ready_o.
REQ-005 SHALL present an accepted entry on the ex_* outputs in the cycle after acceptance if the buffer was empty (latency 1).
REQ-006 SHALL pop the head entry on the edge where ex_valid_o && ex_ready_i.
REQ-007 SHALL deliver entries to EX in acceptance order.
REQ-008 SHALL drive instr_ready_o = (count < BUF_DEPTH) && !hazard && !flush_i.
REQ-009 SHALL NOT have any combinational path from ex_ready_i to instr_ready_o; when the buffer is full, no push occurs even in a cycle with a pop.
REQ-010 SHALL track occupancy with states EMPTY (count=0), PARTIAL and FULL (count=BUF_DEPTH):
- push only increments count
- pop only decrements count
- push and pop together leave count unchanged
- read and write pointers wrap modulo BUF_DEPTH.
REQ-011 SHALL hold ex_valid_o low when EMPTY; ex_* data fields are don't-care then.
REQ-012 SHALL assert hazard when ex_load_valid_i is high, ex_load_rd_i != 0, and ex_load_rd_i equals a source register actually read by instr_i:
- R-type, branch and store read rs1 and rs2
- OP-IMM, load and JALR read rs1
- LUI, AUIPC and JAL read none.
REQ-013 SHALL, on flush_i, set count and both pointers to 0 at the next edge, ignoring any pop in that cycle; ex_valid_o SHALL be 0 the following cycle.
REQ-014 SHALL flag as illegal:
- unknown opcodes
- JALR with funct3 != 0
- stores with funct3[2]=1 or funct3=011
- SYSTEM with funct3=000 and an unsupported funct12, or with rs1/rd nonzero
- CSR funct3=100.
REQ-015 SHALL force reg_write, mem_rd_en and mem_wr_en to 0 for an illegal entry, set ex_illegal_o=1, and still pass the entry to EX.
REQ-016 SHALL force ex_reg_write_o=0 whenever rd=0.
REQ-017 SHALL increment illegal_cnt_o on each accepted illegal instruction, saturating at 255.

Reset
REQ-018 SHALL, while rst_ni=0, asynchronously clear count, pointers, illegal_cnt_o and all buffer control bits, giving ex_valid_o=0 and illegal_cnt_o=0.
REQ-019 SHALL drive instr_ready_o=1 during reset when flush_i=0 and there is no hazard.
REQ-020 SHALL discard in-flight entries when reset asserts mid-operation, with no partial push.

Configuration
REQ-021 SHALL support macro RV32M_EN for OPCODE_OP with funct7=0000001:
- defined: decode as ex_md_en_o=1, ex_md_op_o=funct3, reg_write per REQ-016
- undefined: decode as illegal, with ex_md_en_o and ex_md_op_o tied to 0.

Verification
REQ-022 SHALL cover: ADDI x1,x0,5 (0x00500093) accepted cycle 0 -> cycle 1 ex_valid_o=1, ex_rd_o=1, ex_imm_o=5, ex_reg_write_o=1, ex_alu_op_o=ALU_ADD.
REQ-023 SHALL cover: BUF_DEPTH=2, ex_ready_i=0, three instructions offered -> instr_ready_o=0 after two accepts; ex_ready_i=1 -> all three delivered in order.
REQ-024 SHALL cover: flush_i pulse while FULL -> next cycle count=0, ex_valid_o=0, instr_ready_o=1.
REQ-025 SHALL cover load-use hazard:
- ex_load_valid_i=1, ex_load_rd_i=5, ADD x6,x5,x7 (0x00728333) -> instr_ready_o=0 until ex_load_valid_i falls
- ex_load_rd_i=0 -> no stall.
REQ-026 SHALL cover: MUL x3,x1,x2 (0x022081B3) -> with RV32M_EN ex_md_en_o=1, ex_md_op_o=0; without it ex_illegal_o=1, ex_reg_write_o=0, illegal_cnt_o increments.
REQ-027 SHALL cover: 300 accepted 0xFFFFFFFF words -> illegal_cnt_o=255, every entry ex_illegal_o=1.
